// File: rtl/exe_stage.sv
// exe_stage: pipeline execute stage (ALU, data-SRAM request, bypass bus); optional EXE_ALIGN_CHECK_EN gates misaligned ld.w/st.w
module exe_stage #(
   parameter int ID_BUS_W  = 180,
   parameter int MEM_BUS_W = 71,
   parameter int WR_BUS_W  = 39
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 ID_to_EXE_valid,
   output logic                 EXE_allow_in,
   input  logic [ID_BUS_W-1:0]  ID_to_EXE_bus,
   input  logic                 MEM_allow_in,
   output logic                 EXE_to_MEM_valid,
   output logic [MEM_BUS_W-1:0] EXE_to_MEM_bus,
   output logic [WR_BUS_W-1:0]  EXE_wr_bus,
   output logic                 data_sram_en,
   output logic [3:0]           data_sram_we,
   output logic [31:0]          data_sram_addr,
   output logic [31:0]          data_sram_wdata,
   output logic                 exe_ale
);
   typedef struct packed {
      logic [11:0] alu_op;
      logic [31:0] src1;
      logic [31:0] src2;
      logic        res_from_mem;
      logic        gr_we;
      logic        mem_we;
      logic [4:0]  dest;
      logic [31:0] rkd;
      logic [31:0] pc;
   } exe_bus_t;
   exe_bus_t    ir;
   logic        valid;
   logic [31:0] alu_result;
   logic        mem_op;
   logic        sram_go;
   logic        unused_inst;
   // the instruction word is not needed past decode
   assign unused_inst      = ^ID_to_EXE_bus[31:0];
   assign EXE_allow_in     = ~valid | MEM_allow_in;
   assign EXE_to_MEM_valid = valid;
   assign mem_op           = ir.res_from_mem | ir.mem_we;
`ifdef EXE_ALIGN_CHECK_EN
   assign exe_ale = valid & mem_op & (alu_result[1:0] != 2'b00);
`else
   assign exe_ale = 1'b0;
`endif
   // a request fires only in the cycle MEM takes the instruction, so stalls never duplicate it
   assign sram_go          = valid & MEM_allow_in & ~exe_ale;
   assign data_sram_en     = sram_go & mem_op;
   assign data_sram_we     = {4{sram_go & ir.mem_we}};
   assign data_sram_addr   = alu_result;
   assign data_sram_wdata  = ir.rkd;
   assign EXE_to_MEM_bus   = {ir.res_from_mem, ir.gr_we, ir.dest, alu_result, ir.pc};
   assign EXE_wr_bus       = {ir.gr_we & valid, ir.dest, alu_result, ir.res_from_mem & valid};
   // valid flag advances whenever EXE can take a new slot
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) valid <= 1'b0;
      else if (EXE_allow_in) valid <= ID_to_EXE_valid;
   end
   // instruction register loads only on a real handshake and holds through stalls
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) ir <= '0;
      else if (ID_to_EXE_valid & EXE_allow_in) ir <= ID_to_EXE_bus[ID_BUS_W-1:32];
   end
   // one-hot AND-OR select; an all-zero alu_op yields 0
   always_comb begin
      alu_result = ({32{ir.alu_op[0]}}  & (ir.src1 + ir.src2))
                 | ({32{ir.alu_op[1]}}  & (ir.src1 - ir.src2))
                 | ({32{ir.alu_op[2]}}  & {31'd0, $signed(ir.src1) < $signed(ir.src2)})
                 | ({32{ir.alu_op[3]}}  & {31'd0, ir.src1 < ir.src2})
                 | ({32{ir.alu_op[4]}}  & (ir.src1 & ir.src2))
                 | ({32{ir.alu_op[5]}}  & ~(ir.src1 | ir.src2))
                 | ({32{ir.alu_op[6]}}  & (ir.src1 | ir.src2))
                 | ({32{ir.alu_op[7]}}  & (ir.src1 ^ ir.src2))
                 | ({32{ir.alu_op[8]}}  & (ir.src1 << ir.src2[4:0]))
                 | ({32{ir.alu_op[9]}}  & (ir.src1 >> ir.src2[4:0]))
                 | ({32{ir.alu_op[10]}} & 32'($signed(ir.src1) >>> ir.src2[4:0]))
                 | ({32{ir.alu_op[11]}} & ir.src2);
   end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized and directed checks of exe_stage against a queue-based occupancy model
module tb_exe_stage;
   logic         clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, mem_allow = 1'b0;
   logic [179:0] in_bus = '0;
   logic         allow, to_mem_valid, en, ale;
   logic [70:0]  to_mem_bus;
   logic [38:0]  wr_bus;
   logic [3:0]   we;
   logic [31:0]  addr, wdata;
   int           errors = 0, checks = 0;
   logic [179:0] q[$];
   logic         e_allow, e_mv, e_en, e_ale;
   logic [3:0]   e_we;
   logic [70:0]  e_mbus;
   logic [38:0]  e_wr;
   logic [31:0]  e_wdata;

   exe_stage dut (
      .clk(clk), .resetn(resetn), .ID_to_EXE_valid(in_valid), .EXE_allow_in(allow),
      .ID_to_EXE_bus(in_bus), .MEM_allow_in(mem_allow), .EXE_to_MEM_valid(to_mem_valid),
      .EXE_to_MEM_bus(to_mem_bus), .EXE_wr_bus(wr_bus), .data_sram_en(en), .data_sram_we(we),
      .data_sram_addr(addr), .data_sram_wdata(wdata), .exe_ale(ale)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(logic [11:0] op, logic [31:0] a, logic [31:0] b);
      logic [63:0] ext;
      int sh;
      sh = int'(b[4:0]);
      ext = {{32{a[31]}}, a};
      if (op == 12'h001) return a + b;
      if (op == 12'h002) return a - b;
      if (op == 12'h004) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      if (op == 12'h008) return (a < b) ? 32'd1 : 32'd0;
      if (op == 12'h010) return a & b;
      if (op == 12'h020) return ~(a | b);
      if (op == 12'h040) return a | b;
      if (op == 12'h080) return a ^ b;
      if (op == 12'h100) return a << sh;
      if (op == 12'h200) return a >> sh;
      if (op == 12'h400) return ext[31:0] >> 0 == 0 ? 32'(ext >> sh) : 32'(ext >> sh);
      if (op == 12'h800) return b;
      return 32'd0;
   endfunction

   function automatic logic [179:0] mk(int op, logic [31:0] s1, logic [31:0] s2, logic rfm, logic gwe,
                                       logic mwe, logic [4:0] d, logic [31:0] rkd, logic [31:0] pc);
      logic [11:0] o;
      o = (op < 0) ? 12'd0 : (12'd1 << op);
      return {o, s1, s2, rfm, gwe, mwe, d, rkd, pc, 32'h0};
   endfunction

   // apply inputs on the falling edge and derive expected outputs from the model's current occupant
   task automatic drive(input logic v, input logic [179:0] b, input logic ma);
      logic [179:0] h;
      logic hv, mem;
      logic [31:0] res;
      @(negedge clk);
      in_valid = v; in_bus = b; mem_allow = ma;
      #1;
      hv = q.size() > 0;
      h = hv ? q[0] : '0;
      res = ref_alu(h[179:168], h[167:136], h[135:104]);
      mem = h[103] | h[101];
`ifdef EXE_ALIGN_CHECK_EN
      e_ale = hv & mem & (res[1:0] != 2'b00);
`else
      e_ale = 1'b0;
`endif
      e_allow = !hv || ma;
      e_mv = hv;
      e_en = hv & ma & mem & !e_ale;
      e_we = {4{hv & ma & h[101] & !e_ale}};
      e_mbus = {h[103], h[102], h[100:96], res, h[63:32]};
      e_wr = {h[102] & hv, h[100:96], res, h[103] & hv};
      e_wdata = h[95:64];
   endtask

   // advance the model across the rising edge: leave to MEM, then accept from decode
   task automatic tick();
      logic take;
      take = in_valid && e_allow;
      if (q.size() > 0 && mem_allow) void'(q.pop_front());
      if (take) q.push_back(in_bus);
      @(posedge clk);
   endtask

   task automatic test_reset();
      in_valid = 1'b1; in_bus = mk(0, 32'h3, 32'h4, 1'b1, 1'b1, 1'b1, 5'd7, 32'h55, 32'h40); mem_allow = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      checks++; if (allow !== 1'b1) begin errors++; $display("FAIL reset_allow: got %h want 1", allow); end
      checks++; if (to_mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %h want 0", to_mem_valid); end
      checks++; if (to_mem_bus !== 71'd0) begin errors++; $display("FAIL reset_mbus: got %h want 0", to_mem_bus); end
      checks++; if (wr_bus !== 39'd0) begin errors++; $display("FAIL reset_wr: got %h want 0", wr_bus); end
      checks++; if ({en, we, addr, wdata, ale} !== 70'd0) begin errors++; $display("FAIL reset_sram: got %h want 0", {en, we, addr, wdata, ale}); end
      @(negedge clk);
      in_valid = 1'b0;
      resetn = 1'b1;
      q.delete();
   endtask

   task automatic test_add();
      drive(1'b1, mk(0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, 5'd5, 32'h0, 32'h1C000000), 1'b1);
      tick();
      drive(1'b0, '0, 1'b1);
      checks++; if (to_mem_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %h want 1", to_mem_valid); end
      checks++; if (to_mem_bus[63:32] !== 32'h80000000) begin errors++; $display("FAIL add_result: got %h want 80000000", to_mem_bus[63:32]); end
      checks++; if (wr_bus !== {1'b1, 5'd5, 32'h80000000, 1'b0}) begin errors++; $display("FAIL add_wr: got %h want %h", wr_bus, {1'b1, 5'd5, 32'h80000000, 1'b0}); end
      tick();
   endtask

   task automatic test_alu_ops();
      int ops[3] = '{2, 3, 10};
      logic [31:0] a[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
      logic [31:0] b[3] = '{32'h1, 32'h1, 32'h4};
      logic [31:0] r[3] = '{32'h1, 32'h0, 32'hF8000000};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mk(ops[i], a[i], b[i], 1'b0, 1'b1, 1'b0, 5'd1, 32'h0, 32'h100), 1'b1);
         tick();
         drive(1'b0, '0, 1'b1);
         checks++; if (to_mem_bus[63:32] !== r[i]) begin errors++; $display("FAIL alu_op%0d: got %h want %h", ops[i], to_mem_bus[63:32], r[i]); end
         tick();
      end
   endtask

   task automatic test_store_stall();
      drive(1'b1, mk(0, 32'h1000, 32'h8, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 32'h200), 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mk(0, 32'h1, 32'h2, 1'b0, 1'b1, 1'b0, 5'd2, 32'h0, 32'h204), 1'b0);
         checks++; if (allow !== 1'b0) begin errors++; $display("FAIL st_hold_allow: got %h want 0", allow); end
         checks++; if ({en, we} !== 5'd0) begin errors++; $display("FAIL st_hold_req: got %h want 0", {en, we}); end
         checks++; if (to_mem_valid !== 1'b1) begin errors++; $display("FAIL st_hold_valid: got %h want 1", to_mem_valid); end
         tick();
      end
      drive(1'b0, '0, 1'b1);
      checks++; if ({en, we} !== 5'h1F) begin errors++; $display("FAIL st_release_req: got %h want 1f", {en, we}); end
      checks++; if (addr !== 32'h1008) begin errors++; $display("FAIL st_addr: got %h want 1008", addr); end
      checks++; if (wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL st_wdata: got %h want deadbeef", wdata); end
      tick();
      drive(1'b0, '0, 1'b1);
      checks++; if ({to_mem_valid, en} !== 2'b00) begin errors++; $display("FAIL st_drain: got %h want 0", {to_mem_valid, en}); end
      tick();
   endtask

   task automatic test_load();
      drive(1'b1, mk(0, 32'h2000, 32'h4, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 32'h300), 1'b1);
      tick();
      drive(1'b0, '0, 1'b1);
      checks++; if (wr_bus[0] !== 1'b1 || wr_bus[37:33] !== 5'd3) begin errors++; $display("FAIL ld_wr: got %h want load=1 dest=3", wr_bus); end
      checks++; if (en !== 1'b1 || we !== 4'h0) begin errors++; $display("FAIL ld_req: got en=%h we=%h want en=1 we=0", en, we); end
      tick();
      drive(1'b0, '0, 1'b1);
      checks++; if ({to_mem_valid, wr_bus[38], wr_bus[0], en} !== 4'd0) begin errors++; $display("FAIL ld_after: got %h want 0", {to_mem_valid, wr_bus[38], wr_bus[0], en}); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [179:0] ins[4];
      logic [31:0] got[$];
      int reqs[4] = '{0, 0, 0, 0};
      bit pat[4] = '{1, 0, 1, 1};
      int idx = 0;
      for (int i = 0; i < 4; i++)
         ins[i] = mk(0, 32'h3000, 32'(i * 4), i[0] ? 1'b0 : 1'b1, 1'b0, i[0], 5'(i), 32'h0, 32'h400 + 32'(i * 4));
      for (int c = 0; c < 10; c++) begin
         drive(idx < 4, idx < 4 ? ins[idx] : '0, c < 4 ? pat[c] : 1'b1);
         if (en) reqs[(addr - 32'h3000) >> 2]++;
         if (to_mem_valid && mem_allow) got.push_back(to_mem_bus[31:0]);
         if (allow && idx < 4) idx++;
         tick();
      end
      checks++; if (got.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (i >= got.size() || got[i] !== 32'h400 + 32'(i * 4)) begin errors++; $display("FAIL b2b_order%0d: got %h want %h", i, i < got.size() ? got[i] : 32'hX, 32'h400 + 32'(i * 4)); end
         checks++; if (reqs[i] != 1) begin errors++; $display("FAIL b2b_req%0d: got %0d want 1", i, reqs[i]); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 80; c++) begin
         int r, k;
         r = $urandom_range(0, 12);
         k = $urandom_range(0, 3);
         drive(1'($urandom), mk(r == 12 ? -1 : r, $urandom, ($urandom % 2) ? $urandom : $urandom_range(0, 40),
               k == 1, 1'($urandom), k == 2, 5'($urandom), $urandom, $urandom), ($urandom % 4) != 0);
         checks++; if (allow !== e_allow) begin errors++; $display("FAIL rnd_allow: got %h want %h", allow, e_allow); end
         checks++; if (to_mem_valid !== e_mv) begin errors++; $display("FAIL rnd_valid: got %h want %h", to_mem_valid, e_mv); end
         checks++; if ({en, we, ale} !== {e_en, e_we, e_ale}) begin errors++; $display("FAIL rnd_req: got %h want %h", {en, we, ale}, {e_en, e_we, e_ale}); end
         if (e_mv) begin
            checks++; if (to_mem_bus !== e_mbus) begin errors++; $display("FAIL rnd_mbus: got %h want %h", to_mem_bus, e_mbus); end
            checks++; if (wr_bus !== e_wr) begin errors++; $display("FAIL rnd_wr: got %h want %h", wr_bus, e_wr); end
            checks++; if ({addr, wdata} !== {e_mbus[63:32], e_wdata}) begin errors++; $display("FAIL rnd_addr: got %h want %h", {addr, wdata}, {e_mbus[63:32], e_wdata}); end
         end else begin
            checks++; if ({wr_bus[38], wr_bus[0]} !== 2'b00) begin errors++; $display("FAIL rnd_idle_wr: got %h want 0", {wr_bus[38], wr_bus[0]}); end
         end
         tick();
      end
      drive(1'b0, '0, 1'b1);
      tick();
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b1, mk(0, 32'h1000, 32'h10, 1'b0, 1'b0, 1'b1, 5'd0, 32'h12345678, 32'h500), 1'b1);
      tick();
      drive(1'b0, '0, 1'b0);
      tick();
      #2;
      resetn = 1'b0;
      #1;
      checks++; if ({to_mem_valid, en, we} !== 6'd0) begin errors++; $display("FAIL rst_mid: got %h want 0", {to_mem_valid, en, we}); end
      checks++; if (allow !== 1'b1) begin errors++; $display("FAIL rst_mid_allow: got %h want 1", allow); end
      q.delete();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_align();
      drive(1'b1, mk(0, 32'h1000, 32'h2, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 32'h600), 1'b1);
      tick();
      drive(1'b0, '0, 1'b1);
`ifdef EXE_ALIGN_CHECK_EN
      checks++; if ({ale, en, we} !== 6'b100000) begin errors++; $display("FAIL align_gate: got %h want 20", {ale, en, we}); end
`else
      checks++; if ({ale, en, we} !== 6'b010000) begin errors++; $display("FAIL align_off: got %h want 10", {ale, en, we}); end
`endif
      checks++; if (to_mem_valid !== 1'b1) begin errors++; $display("FAIL align_adv: got %h want 1", to_mem_valid); end
      tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_alu_ops();
      test_store_stall();
      test_load();
      test_back_to_back();
      test_random();
      test_reset_mid_stall();
      test_align();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage of the 5-stage in-order pipeline. Sits between the decode stage and the memory stage.
- Latches the 180-bit decode bus under a valid/allow_in handshake.
- Computes the ALU result.
- Issues the data-SRAM request for ld.w/st.w.
- Forwards {result, dest, load} back to decode for bypass and load-use stall.
- Passes a packed bus on to the memory stage.

Parameters:
ID_BUS_W, 180, width of ID_to_EXE_bus
MEM_BUS_W, 71, width of EXE_to_MEM_bus
WR_BUS_W, 39, width of EXE_wr_bus

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ID_to_EXE_valid  in  1  decode has a valid instruction
EXE_allow_in  out  1  EXE can accept this cycle
ID_to_EXE_bus  in  180  {alu_op[179:168], alu_src1[167:136], alu_src2[135:104], res_from_mem[103], gr_we[102], mem_we[101], dest[100:96], rkd_value[95:64], pc[63:32], inst[31:0]}
MEM_allow_in  in  1  memory stage can accept
EXE_to_MEM_valid  out  1  valid toward memory stage
EXE_to_MEM_bus  out  71  {res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
EXE_wr_bus  out  39  {EXE_grwe[38], EXE_dest[37:33], EXE_f_result[32:1], EXE_load[0]}
data_sram_en  out  1  data SRAM access enable
data_sram_we  out  4  byte write enables
data_sram_addr  out  32  byte address
data_sram_wdata  out  32  store data
exe_ale  out  1  address-misaligned flag (see Optional Feature)

Behaviour:
- Reset is asynchronous on resetn low.
  - EXE_valid clears to 0 and the bus register clears to 0.
  - All outputs therefore go to 0 while in reset, except EXE_allow_in, which is 1.
- EXE_ready_go = 1. Every operation completes in 1 cycle in EXE.
- EXE_allow_in = ~EXE_valid | (EXE_ready_go & MEM_allow_in).
- EXE_to_MEM_valid = EXE_valid & EXE_ready_go.
- Valid register: on a clk edge with EXE_allow_in=1, EXE_valid <= ID_to_EXE_valid. Otherwise it holds.
- Bus register: loads ID_to_EXE_bus only when ID_to_EXE_valid & EXE_allow_in. It holds on a stall.
- ALU: alu_op is one-hot, bit 0 to bit 11 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - add and sub are mod 2^32.
  - slt compares signed; sltu compares unsigned.
  - Shift amount is src2[4:0].
  - sra sign-fills.
  - lui result = src2.
  - An all-zero alu_op gives result 0.
  - Multiple set bits are illegal, and the result is undefined.
- Memory request:
  - data_sram_en = EXE_valid & MEM_allow_in & (res_from_mem | mem_we).
  - data_sram_we = {4{mem_we & EXE_valid & MEM_allow_in}}.
  - data_sram_addr = alu_result.
  - data_sram_wdata = rkd_value.
  - The SRAM is synchronous; read data appears in the memory stage the following cycle.
  - No request is issued while MEM stalls, so a request is never duplicated.
- EXE_wr_bus:
  - EXE_grwe = gr_we & EXE_valid.
  - EXE_dest = dest.
  - EXE_f_result = alu_result.
  - EXE_load = res_from_mem & EXE_valid.
- With EXE_valid=0, no SRAM enable, grwe or load may assert, whatever stale bus contents remain.
- Simultaneous events:
  - If MEM stalls while decode offers an instruction, EXE holds its instruction and EXE_allow_in=0.
  - If EXE is empty and MEM stalls, the new instruction is still accepted.
- Branch flush is resolved in decode. EXE has no flush input.
- A resetn assertion mid-stall discards the held instruction immediately; no SRAM request is issued.

Optional Feature:
Macro EXE_ALIGN_CHECK_EN.
- When defined:
  - exe_ale = EXE_valid & (res_from_mem | mem_we) & (alu_result[1:0] != 0).
  - When exe_ale=1, data_sram_en and data_sram_we are forced to 0.
  - The instruction still advances to MEM.
- When not defined: exe_ale is tied to 0 and no gating is applied.

Test Plan:
- add.w with src1=0x7FFFFFFF, src2=1, gr_we=1, dest=5, MEM_allow_in=1 -> the next cycle EXE_to_MEM_valid=1, alu_result=0x80000000, EXE_wr_bus={1,5,0x80000000,0}.
- slt with src1=0xFFFFFFFF, src2=1 -> result 1; sltu with the same operands -> result 0; sra with src1=0x80000000, src2=4 -> result 0xF8000000.
- st.w with src1=0x1000, src2=8, rkd=0xDEADBEEF, MEM_allow_in held 0 for 3 cycles and then 1 -> EXE_allow_in=0 during the hold; data_sram_en/we asserted only in the release cycle, with addr=0x1008, we=0xF, wdata=0xDEADBEEF.
- ld.w with dest=3 -> EXE_load=1 and EXE_dest=3 while valid; data_sram_en=1, we=0; on the next cycle with no new input, EXE_valid=0 and EXE_wr_bus[38]=0, [0]=0.
- Back-to-back issue of 4 instructions with MEM_allow_in toggling 1,0,1,1 -> all 4 reach MEM in order with no loss or duplicate, and each sends exactly one SRAM request.
- resetn pulled low mid-stall with a store held -> asynchronous clear: EXE_valid=0 and data_sram_en=0 before the next edge; with EXE_ALIGN_CHECK_EN, ld.w at addr 0x1002 -> exe_ale=1 and data_sram_en=0.
